// File: rtl/ycc_block_buffer.sv
// Ping-pong Y/Cb/Cr block buffer: stores one MCU (three raster-order blocks)
// per bank and replays it as aligned (y, cb, cr) pixel triples.
module ycc_block_buffer #(
   parameter int DATA_W  = 8,
   parameter int BLK_PIX = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          sample_in,
   input  logic [1:0]                 comp_in,
   input  logic                       valid_in,
   output logic                       ready_out,
   output logic [DATA_W-1:0]          y,
   output logic [DATA_W-1:0]          cb,
   output logic [DATA_W-1:0]          cr,
   output logic [$clog2(BLK_PIX)-1:0] pix_idx,
   output logic                       valid_out,
   input  logic                       out_ready,
   output logic                       blk_done,
   output logic                       err
);

   // Handshake on both sides: a beat transfers on a rising edge where valid and
   // ready are both high; once valid is raised its data holds until that edge.

   localparam int IDX_W  = $clog2(BLK_PIX);
   localparam int MCU_W  = 3 * BLK_PIX;
   localparam int WC_W   = $clog2(MCU_W);
   localparam int ADDR_W = $clog2(2 * MCU_W);

   // Bank b occupies words b*MCU_W .. b*MCU_W+MCU_W-1, laid out Y, Cb, Cr.
   logic [DATA_W-1:0] mem [0:2*MCU_W-1];

   logic [1:0]       full;
   logic             wr_bank;
   logic             rd_bank;
   logic [WC_W-1:0]  wc;
   logic [IDX_W:0]   rc;

   logic              accept;
   logic              wc_last;
   logic [1:0]        exp_comp;
   logic [ADDR_W-1:0] wr_addr;

   logic              xfer;
   logic              last_xfer;
   logic              load_en;
   logic              nb;
   logic              src_bank;
   logic [IDX_W-1:0]  src_idx;
   logic              src_ok;
   logic [ADDR_W-1:0] y_addr;
   logic [ADDR_W-1:0] cb_addr;
   logic [ADDR_W-1:0] cr_addr;

   assign ready_out = !full[wr_bank] && !rst;
   assign accept    = valid_in && ready_out;
   assign wc_last   = (wc == WC_W'(MCU_W - 1));
   assign exp_comp  = 2'(wc >> IDX_W);
   assign wr_addr   = wr_bank ? (ADDR_W'(MCU_W) + ADDR_W'(wc)) : ADDR_W'(wc);

   assign xfer      = valid_out && out_ready;
   assign last_xfer = xfer && (pix_idx == IDX_W'(BLK_PIX - 1));
   assign load_en   = !valid_out || out_ready;
   assign nb        = ~rd_bank;

   // On the final transfer of a bank, pixel 0 of the other bank is fetched so
   // consecutive MCUs stream without a bubble.
   assign src_bank  = last_xfer ? nb : rd_bank;
   assign src_idx   = last_xfer ? '0 : rc[IDX_W-1:0];
   assign src_ok    = last_xfer ? full[nb]
                                : (full[rd_bank] && (rc < (IDX_W+1)'(BLK_PIX)));
   assign y_addr    = (src_bank ? ADDR_W'(MCU_W) : '0) + ADDR_W'(src_idx);
   assign cb_addr   = y_addr + ADDR_W'(BLK_PIX);
   assign cr_addr   = y_addr + ADDR_W'(2 * BLK_PIX);

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_addr] <= sample_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full      <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wc        <= '0;
         rc        <= '0;
         err       <= 1'b0;
         valid_out <= 1'b0;
         y         <= '0;
         cb        <= '0;
         cr        <= '0;
         pix_idx   <= '0;
         blk_done  <= 1'b0;
      end else begin
         blk_done <= last_xfer;

         // A mis-tagged sample is still stored at the counter position.
         if (accept) begin
            if (comp_in != exp_comp) begin
               err <= 1'b1;
            end
            if (wc_last) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
               wc            <= '0;
            end else begin
               wc <= wc + WC_W'(1);
            end
         end

         if (last_xfer) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= nb;
            rc            <= '0;
         end

         if (load_en) begin
            if (src_ok) begin
               y         <= mem[y_addr];
               cb        <= mem[cb_addr];
               cr        <= mem[cr_addr];
               pix_idx   <= src_idx;
               valid_out <= 1'b1;
               rc        <= (IDX_W+1)'(src_idx) + (IDX_W+1)'(1);
            end else begin
               valid_out <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ycc_block_buffer.sv
// Bench for ycc_block_buffer: scenario table plus hand sequences, with a
// pixel scoreboard fed by the sample driver and drained by an output monitor.
`timescale 1ns/1ps
module tb_ycc_block_buffer;

   localparam int DATA_W  = 8;
   localparam int BLK_PIX = 64;
   localparam int IDX_W   = 6;
   localparam int W       = 3 * DATA_W + IDX_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] sample_in = '0;
   logic [1:0]        comp_in = '0;
   logic              valid_in = 1'b0;
   logic              ready_out;
   logic [DATA_W-1:0] y, cb, cr;
   logic [IDX_W-1:0]  pix_idx;
   logic              valid_out;
   logic              out_ready = 1'b1;
   logic              blk_done;
   logic              err;

   ycc_block_buffer #(.DATA_W(DATA_W), .BLK_PIX(BLK_PIX)) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .comp_in(comp_in),
      .valid_in(valid_in), .ready_out(ready_out), .y(y), .cb(cb), .cr(cr),
      .pix_idx(pix_idx), .valid_out(valid_out), .out_ready(out_ready),
      .blk_done(blk_done), .err(err)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int pop_cnt = 0;
   int stall_cnt = 0;
   int mode = 0;   // out_ready: 0 always 1, 1 toggle, 2 random, 3 held low

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic         prev_last;
      logic         prev_stall;
      logic [W-1:0] prev_out;
      logic [W-1:0] got;
      logic [W-1:0] e;
      prev_last = 1'b0;
      prev_stall = 1'b0;
      prev_out = '0;
      forever begin
         @(negedge clk);
         got = {y, cb, cr, pix_idx};
         if (rst) begin
            prev_last = 1'b0;
            prev_stall = 1'b0;
         end else begin
            check("blk_done_timing", blk_done, prev_last);
            if (prev_stall) check("stall_hold", {valid_out, got}, {1'b1, prev_out});
            if (valid_out && out_ready) begin
               pop_cnt++;
               check("sb_nonempty", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("pixel", got, e);
               end
            end
            if (blk_done) done_cnt++;
            prev_last = valid_out && out_ready && (pix_idx == IDX_W'(BLK_PIX - 1));
            prev_stall = valid_out && !out_ready;
            prev_out = got;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] s, input logic [1:0] c, output bit ok);
      sample_in = s;
      comp_in = c;
      valid_in = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 4000 && !ok; t++) begin
         @(negedge clk);
         if (ready_out) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end else begin
            stall_cnt++;
         end
      end
   endtask

   task automatic feed_mcu(input int m, input int bad_pos, input logic [1:0] bad_comp);
      logic [7:0] smp [0:191];
      logic [7:0] s;
      logic [1:0] c;
      bit ok;
      for (int w = 0; w < 192; w++) begin
         s = 8'((w + 7 * m) % 256);
         c = 2'(w / 64);
         if (w == bad_pos) c = bad_comp;
         send(s, c, ok);
         check("accept", ok, 1);
         if (!ok) return;
         smp[w] = s;
      end
      for (int k = 0; k < 64; k++) begin
         exp_q.push_back({smp[k], smp[64 + k], smp[128 + k], IDX_W'(k)});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {ready_out, valid_out, blk_done, err, y, cb, cr, pix_idx}, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      done_cnt = 0;
      pop_cnt = 0;
      stall_cnt = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0 && !valid_out) break;
         @(negedge clk);
      end
      check("drain_empty", exp_q.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   // ---------------- scenario table ----------------
   typedef struct {
      int         n_mcu;
      int         mode;
      int         bad_pos;
      logic [1:0] bad_comp;
      int         exp_done;
      bit         exp_err;
      int         exp_stall;   // -1: not checked
   } vec_t;

   vec_t vecs[6];

   initial begin
      bit ok;
      bit seen;
      vecs[0] = '{1, 0, -1,  2'd0, 1, 1'b0,  0};
      vecs[1] = '{4, 0, -1,  2'd0, 4, 1'b0,  0};
      vecs[2] = '{2, 1, -1,  2'd0, 2, 1'b0,  0};
      vecs[3] = '{1, 0, 5,   2'd1, 1, 1'b1,  0};
      vecs[4] = '{3, 2, -1,  2'd0, 3, 1'b0, -1};
      vecs[5] = '{1, 1, 130, 2'd3, 1, 1'b1,  0};

      // Latency: one idle cycle after the final Cr, then pixel 0.
      mode = 0;
      do_reset();
      feed_mcu(0, -1, 2'd0);
      valid_in = 1'b0;
      @(negedge clk);
      check("idle_cycle_valid", valid_out, 0);
      @(negedge clk);
      check("first_valid", {valid_out, pix_idx}, {1'b1, IDX_W'(0)});
      drain();
      check("latency_done", done_cnt, 1);

      for (int v = 0; v < 6; v++) begin
         mode = vecs[v].mode;
         do_reset();
         for (int m = 0; m < vecs[v].n_mcu; m++) begin
            feed_mcu(m, (m == 0) ? vecs[v].bad_pos : -1, vecs[v].bad_comp);
         end
         valid_in = 1'b0;
         drain();
         check($sformatf("v%0d_done", v), done_cnt, vecs[v].exp_done);
         check($sformatf("v%0d_pixels", v), pop_cnt, 64 * vecs[v].n_mcu);
         check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
         if (vecs[v].exp_stall >= 0) check($sformatf("v%0d_ready_drop", v), stall_cnt, vecs[v].exp_stall);
      end

      // Back-pressure: both banks fill, then a drain frees the write bank.
      mode = 3;
      do_reset();
      feed_mcu(0, -1, 2'd0);
      feed_mcu(1, -1, 2'd0);
      @(negedge clk);
      check("both_full_ready", ready_out, 0);
      check("held_pixel0", {valid_out, pix_idx}, {1'b1, IDX_W'(0)});
      fork
         feed_mcu(2, -1, 2'd0);
         begin
            repeat (20) @(posedge clk);
            mode = 0;
            seen = 1'b0;
            for (int i = 0; i < 500 && !seen; i++) begin
               @(negedge clk);
               if (blk_done) seen = 1'b1;
            end
            check("first_blk_done_seen", seen, 1);
            check("ready_after_drain", ready_out, 1);
         end
      join
      valid_in = 1'b0;
      drain();
      check("bp_done", done_cnt, 3);
      check("bp_pixels", pop_cnt, 192);
      check("bp_err", err, 0);

      // Reset mid-MCU discards the partial bank and clears err.
      mode = 0;
      do_reset();
      for (int w = 0; w < 100; w++) begin
         send(8'(w), (w == 3) ? 2'd1 : 2'(w / 64), ok);
         check("mid_accept", ok, 1);
      end
      @(negedge clk);
      check("mid_err_set", err, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_outputs", {valid_out, ready_out, err, blk_done}, 4'b0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      done_cnt = 0;
      pop_cnt = 0;
      feed_mcu(5, -1, 2'd0);
      valid_in = 1'b0;
      drain();
      check("fresh_done", done_cnt, 1);
      check("fresh_pixels", pop_cnt, 64);
      check("fresh_err", err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
